fll_ctrl: RTL and testbench

Frequency-lock controller that sits directly downstream of `pfd`. It consumes the `fast`/`slow` flags and drives the DCO control word. It first runs a binary (SAR) search over the code, then tracks in ±1 steps, and reports lock. It also owns the clear of the `pfd` counters, so that every decision window starts from a zero count difference.

---
 rtl/fll_ctrl.sv | 153 +++++++++++++++
 tb/tb_fll_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fll_ctrl.sv
// Frequency-lock controller: SAR search over the DCO code, then +/-1 tracking with lock detect.
// Owns the pfd counter clear so every decision window starts from a zero count difference.
module fll_ctrl #(
  parameter int unsigned CODE_W     = 8,
  parameter int unsigned WIN_CYCLES = 16,
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned LOCK_CNT   = 4,
  parameter bit          INVERT     = 1'b0
) (
  input  logic              ref_clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fast,
  input  logic              slow,
  output logic [CODE_W-1:0] code,
  output logic              pfd_clr,
  output logic              searching,
  output logic              locked,
  output logic              sat
);

  localparam int unsigned IdxW   = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int unsigned CntMax = (WIN_CYCLES > CLR_CYCLES) ? WIN_CYCLES : CLR_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned QW     = $clog2(LOCK_CNT + 1);

  localparam logic [CODE_W-1:0] MidCode = CODE_W'(1) << (CODE_W - 1);
  localparam logic [CODE_W-1:0] MaxCode = '1;
  localparam logic [IdxW-1:0]   TopIdx  = IdxW'(CODE_W - 1);
  localparam logic [CntW-1:0]   ClrLast = CntW'(CLR_CYCLES - 1);
  localparam logic [CntW-1:0]   WinLast = CntW'(WIN_CYCLES - 1);
  localparam logic [QW-1:0]     LockMax = QW'(LOCK_CNT);
  localparam logic [QW-1:0]     LockPre = QW'(LOCK_CNT - 1);

  typedef enum logic [1:0] {StIdle, StSar, StTrack} mode_e;
  typedef enum logic [1:0] {PhClr, PhWait, PhEval} phase_e;

  mode_e             mode_q;
  phase_e            phase_q;
  logic [CntW-1:0]   cnt_q;
  logic [IdxW-1:0]   bit_idx_q;
  logic [QW-1:0]     quiet_cnt_q;
  logic              fast_m_q, fast_s_q, slow_m_q, slow_s_q;
  logic              sel_flag, oth_flag, up, dn;
  logic [CODE_W-1:0] sar_code;

  assign sel_flag = INVERT ? fast_s_q : slow_s_q;
  assign oth_flag = INVERT ? slow_s_q : fast_s_q;
  assign up       = sel_flag & ~oth_flag;
  assign dn       = oth_flag & ~sel_flag;

  // Trial result for the current SAR bit, with the next lower bit pre-set.
  always_comb begin
    sar_code = code;
    if (dn) sar_code[bit_idx_q] = 1'b0;
    if (bit_idx_q != '0) sar_code[bit_idx_q - 1'b1] = 1'b1;
  end

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      mode_q      <= StIdle;
      phase_q     <= PhClr;
      cnt_q       <= '0;
      bit_idx_q   <= TopIdx;
      quiet_cnt_q <= '0;
      fast_m_q    <= 1'b0;
      fast_s_q    <= 1'b0;
      slow_m_q    <= 1'b0;
      slow_s_q    <= 1'b0;
      code        <= MidCode;
      pfd_clr     <= 1'b1;
      searching   <= 1'b0;
      locked      <= 1'b0;
      sat         <= 1'b0;
    end else begin
      fast_m_q <= fast;
      fast_s_q <= fast_m_q;
      slow_m_q <= slow;
      slow_s_q <= slow_m_q;
      if (!en) begin
        mode_q    <= StIdle;
        pfd_clr   <= 1'b1;
        searching <= 1'b0;
        locked    <= 1'b0;
        sat       <= 1'b0;
      end else begin
        unique case (mode_q)
          StIdle: begin
            mode_q      <= StSar;
            phase_q     <= PhClr;
            cnt_q       <= '0;
            bit_idx_q   <= TopIdx;
            quiet_cnt_q <= '0;
            code        <= MidCode;
            pfd_clr     <= 1'b1;
            searching   <= 1'b1;
          end
          StSar, StTrack: begin
            unique case (phase_q)
              PhClr: begin
                if (cnt_q == ClrLast) begin
                  phase_q <= PhWait;
                  cnt_q   <= '0;
                  pfd_clr <= 1'b0;
                end else begin
                  cnt_q <= cnt_q + 1'b1;
                end
              end
              PhWait: begin
                if (cnt_q == WinLast) begin
                  phase_q <= PhEval;
                  cnt_q   <= '0;
                end else begin
                  cnt_q <= cnt_q + 1'b1;
                end
              end
              PhEval: begin
                phase_q <= PhClr;
                pfd_clr <= 1'b1;
                if (mode_q == StSar) begin
                  code <= sar_code;
                  if (bit_idx_q == '0) begin
                    mode_q    <= StTrack;
                    searching <= 1'b0;
                  end else begin
                    bit_idx_q <= bit_idx_q - 1'b1;
                  end
                end else if (up || dn) begin
                  quiet_cnt_q <= '0;
                  locked      <= 1'b0;
                  // A request beyond either end pins the code and flags saturation.
                  if ((up && code == MaxCode) || (dn && code == '0)) begin
                    sat <= 1'b1;
                  end else begin
                    sat  <= 1'b0;
                    code <= up ? code + 1'b1 : code - 1'b1;
                  end
                end else begin
                  sat <= 1'b0;
                  if (quiet_cnt_q != LockMax) quiet_cnt_q <= quiet_cnt_q + 1'b1;
                  if (quiet_cnt_q >= LockPre) locked <= 1'b1;
                end
              end
              default: phase_q <= PhClr;
            endcase
          end
          default: mode_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fll_ctrl.sv
// Bench for fll_ctrl: reset/entry vector table, directed lock/saturation/abort sequences,
// and randomized stimulus checked every cycle against a window-arithmetic reference model.
module tb_fll_ctrl;

  localparam int W    = 8;
  localparam int WIN  = 16;
  localparam int CLR  = 2;
  localparam int LOCK = 4;
  localparam int P    = CLR + WIN + 1;
  localparam int MID  = 1 << (W - 1);
  localparam int MAXC = (1 << W) - 1;

  logic         ref_clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         fast = 1'b0;
  logic         slow = 1'b0;
  logic [W-1:0] code;
  logic         pfd_clr, searching, locked, sat;

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus source: 0 = DCO model around target, 1 = forced flags, 2 = random flags.
  int   src = 1;
  int   target = 0;
  logic ff = 1'b0, fs = 1'b0;

  // Reference model state: run flag plus cycle count since the first CLR of the run.
  bit m_run = 0;
  int m_t = 0;
  int m_code = MID;
  int m_quiet = 0;
  bit m_locked = 0, m_sat = 0;
  bit h_f[2] = '{0, 0};
  bit h_s[2] = '{0, 0};

  fll_ctrl #(
    .CODE_W(W), .WIN_CYCLES(WIN), .CLR_CYCLES(CLR), .LOCK_CNT(LOCK), .INVERT(1'b0)
  ) dut (
    .ref_clk(ref_clk), .rst(rst), .en(en), .fast(fast), .slow(slow), .code(code),
    .pfd_clr(pfd_clr), .searching(searching), .locked(locked), .sat(sat)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit f, input bit s);
    bit up, dn;
    int w, b;
    if (r) begin
      m_run = 0; m_t = 0; m_code = MID; m_quiet = 0; m_locked = 0; m_sat = 0;
      h_f = '{0, 0}; h_s = '{0, 0};
      return;
    end
    // Flags seen in the cycle just ending are the inputs from two edges back.
    up = h_s[1] && !h_f[1];
    dn = h_f[1] && !h_s[1];
    if (!e) begin
      m_run = 0; m_locked = 0; m_sat = 0;
    end else if (!m_run) begin
      m_run = 1; m_t = 0; m_code = MID; m_quiet = 0; m_locked = 0; m_sat = 0;
    end else begin
      if (m_t % P == P - 1) begin
        w = m_t / P;
        if (w < W) begin
          b = W - 1 - w;
          if (dn) m_code = m_code & ~(1 << b);
          if (b > 0) m_code = m_code | (1 << (b - 1));
        end else if (up || dn) begin
          m_quiet = 0; m_locked = 0;
          if (up && m_code == MAXC) m_sat = 1;
          else if (dn && m_code == 0) m_sat = 1;
          else begin
            m_sat = 0;
            m_code = up ? m_code + 1 : m_code - 1;
          end
        end else begin
          m_sat = 0;
          if (m_quiet < LOCK) m_quiet++;
          if (m_quiet >= LOCK) m_locked = 1;
        end
      end
      m_t++;
    end
    h_f[1] = h_f[0]; h_f[0] = f;
    h_s[1] = h_s[0]; h_s[0] = s;
  endtask

  // Called at a falling edge: apply inputs, advance model, clock once, compare at next fall.
  task automatic tick(input bit r, input bit e);
    rst = r;
    en  = e;
    case (src)
      0:       begin slow = (m_code < target); fast = (m_code > target); end
      1:       begin fast = ff; slow = fs; end
      default: begin fast = 1'($urandom_range(0, 1)); slow = 1'($urandom_range(0, 1)); end
    endcase
    model_step(r, e, fast, slow);
    @(posedge ref_clk);
    @(negedge ref_clk);
    chk("m_code", 32'(code), 32'(m_code));
    chk("m_pfd_clr", 32'(pfd_clr), 32'(!m_run || (m_t % P) < CLR));
    chk("m_searching", 32'(searching), 32'(m_run && m_t < W * P));
    chk("m_locked", 32'(locked), 32'(m_locked));
    chk("m_sat", 32'(sat), 32'(m_sat));
  endtask

  typedef struct {
    bit r; bit e;
    logic [W-1:0] code; logic clr; logic srch; logic lk; logic st;
  } vec_t;

  initial begin
    vec_t vt[8];
    logic [W-1:0] vis[8];
    int srch_cnt, clr_cnt;

    vt[0] = '{r: 1, e: 0, code: 8'h80, clr: 1, srch: 0, lk: 0, st: 0};
    vt[1] = '{r: 0, e: 0, code: 8'h80, clr: 1, srch: 0, lk: 0, st: 0};
    vt[2] = '{r: 0, e: 1, code: 8'h80, clr: 1, srch: 1, lk: 0, st: 0};
    vt[3] = '{r: 0, e: 1, code: 8'h80, clr: 1, srch: 1, lk: 0, st: 0};
    vt[4] = '{r: 0, e: 1, code: 8'h80, clr: 0, srch: 1, lk: 0, st: 0};
    vt[5] = '{r: 0, e: 0, code: 8'h80, clr: 1, srch: 0, lk: 0, st: 0};
    vt[6] = '{r: 1, e: 1, code: 8'h80, clr: 1, srch: 0, lk: 0, st: 0};
    vt[7] = '{r: 0, e: 1, code: 8'h80, clr: 1, srch: 1, lk: 0, st: 0};

    @(negedge ref_clk);
    src = 1; ff = 0; fs = 0;
    for (int i = 0; i < 8; i++) begin
      tick(vt[i].r, vt[i].e);
      chk("tbl_code", 32'(code), 32'(vt[i].code));
      chk("tbl_pfd_clr", 32'(pfd_clr), 32'(vt[i].clr));
      chk("tbl_searching", 32'(searching), 32'(vt[i].srch));
      chk("tbl_locked", 32'(locked), 32'(vt[i].lk));
      chk("tbl_sat", 32'(sat), 32'(vt[i].st));
    end

    // SAR toward 0x5A, then lock.
    vis = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};
    src = 0; target = 8'h5A; srch_cnt = 0; clr_cnt = 0;
    tick(1, 0);
    for (int k = 1; k <= 229; k++) begin
      tick(0, 1);
      if (searching) srch_cnt++;
      if ((k - 1) % P == 0 && k <= 134) chk("sar_visit", 32'(code), 32'(vis[(k - 1) / P]));
      if (k >= 153 && k <= 228 && pfd_clr) clr_cnt++;
      if (k == 228) chk("lock_early", 32'(locked), 0);
    end
    chk("sar_search_cycles", 32'(srch_cnt), 152);
    chk("sar_final_code", 32'(code), 32'h5A);
    chk("lock_asserted", 32'(locked), 1);
    chk("track_clr_pulses", 32'(clr_cnt), 8);

    // Target step while locked.
    target = 8'h5C;
    for (int k = 230; k <= 343; k++) begin
      tick(0, 1);
      if (k == 248) begin
        chk("step1_code", 32'(code), 32'h5B);
        chk("step1_unlock", 32'(locked), 0);
      end
      if (k == 267) chk("step2_code", 32'(code), 32'h5C);
      if (k == 342) chk("relock_early", 32'(locked), 0);
    end
    chk("relock", 32'(locked), 1);
    chk("relock_code", 32'(code), 32'h5C);

    // Saturation at both ends.
    for (int m = 0; m < 2; m++) begin
      src = 1; ff = (m == 1); fs = (m == 0);
      tick(1, 0);
      for (int k = 1; k <= 191; k++) begin
        tick(0, 1);
        if (k == 153) chk("sat_sar_end", 32'(code), (m == 0) ? 32'hFF : 32'h00);
        if (k == 153) chk("sat_not_yet", 32'(sat), 0);
        if (k == 172) chk("sat_set", 32'(sat), 1);
      end
      chk("sat_hold_code", 32'(code), (m == 0) ? 32'hFF : 32'h00);
      chk("sat_hold", 32'(sat), 1);
    end

    // Both flags high: all quiet, SAR ends at max, then lock; drop en mid-WAIT.
    src = 1; ff = 1; fs = 1;
    tick(1, 0);
    for (int k = 1; k <= 237; k++) begin
      tick(0, 1);
      if (k == 153) chk("quiet_sar_end", 32'(code), 32'hFF);
      if (k == 228) chk("quiet_lock_early", 32'(locked), 0);
      if (k == 229) chk("quiet_lock", 32'(locked), 1);
    end
    tick(0, 0);
    chk("endrop_clr", 32'(pfd_clr), 1);
    chk("endrop_locked", 32'(locked), 0);
    chk("endrop_search", 32'(searching), 0);
    chk("endrop_code", 32'(code), 32'hFF);
    tick(0, 1);
    chk("reen_code", 32'(code), 32'h80);
    chk("reen_search", 32'(searching), 1);

    // Reset in the middle of the SAR.
    src = 0; target = 8'h5A;
    for (int k = 0; k < 49; k++) tick(0, 1);
    chk("midsar_code", 32'(code), 32'h60);
    tick(1, 1);
    chk("rst_code", 32'(code), 32'h80);
    chk("rst_clr", 32'(pfd_clr), 1);
    chk("rst_search", 32'(searching), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_sat", 32'(sat), 0);

    // Randomized segments against the model.
    for (int seg = 0; seg < 40; seg++) begin
      target = $urandom_range(0, MAXC);
      src = $urandom_range(0, 2);
      ff = 1'($urandom_range(0, 1));
      fs = 1'($urandom_range(0, 1));
      for (int k = 0; k < int'($urandom_range(40, 300)); k++) begin
        tick($urandom_range(0, 499) == 0, $urandom_range(0, 149) != 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
